// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / forwarding / scoreboard controller.
package pipe_hazard_ctrl_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int RADDR_W_DEF = 5;

  // Forwarding source indices; lower index is the younger stage.
  localparam int FWD_EX  = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_WB  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_port_sel.sv
// Per-read-port forwarding priority match and operand mux.
// The youngest matching source wins; nvld flags a load result not yet available.
module fwd_port_sel
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int NFWD    = 3
) (
  input  logic                    re,
  input  logic [RADDR_W-1:0]      raddr,
  input  logic [NFWD-1:0]         fwd_we,
  input  logic [NFWD*RADDR_W-1:0] fwd_waddr,
  input  logic [NFWD*XLEN-1:0]    fwd_data,
  input  logic [NFWD-1:0]         fwd_dvld,
  output logic                    sel,
  output logic [XLEN-1:0]         data,
  output logic                    nvld
);

  // Scan oldest to youngest so the youngest match is written last and wins; x0 never forwards.
  always_comb begin
    sel  = 1'b0;
    data = '0;
    nvld = 1'b0;
    if (re && (raddr != '0)) begin
      for (int s = NFWD - 1; s >= FWD_EX; s--) begin
        if (fwd_we[s] && (fwd_waddr[s*RADDR_W +: RADDR_W] == raddr)) begin
          sel  = 1'b1;
          data = fwd_data[s*XLEN +: XLEN];
          nvld = !fwd_dvld[s];
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and scoreboard controller sitting beside the ID stage.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall/flush event counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int RADDR_W    = RADDR_W_DEF,
  parameter int NRD        = 2,
  parameter int NFWD       = 3,
  parameter int MC_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid_i,
  input  logic [NRD-1:0]          id_re_i,
  input  logic [NRD*RADDR_W-1:0]  id_raddr_i,
  input  logic [RADDR_W-1:0]      id_waddr_i,
  input  logic                    id_we_i,
  input  logic [NFWD-1:0]         fwd_we_i,
  input  logic [NFWD*RADDR_W-1:0] fwd_waddr_i,
  input  logic [NFWD*XLEN-1:0]    fwd_data_i,
  input  logic [NFWD-1:0]         fwd_dvld_i,
  input  logic                    mc_start_i,
  input  logic                    mc_done_i,
  input  logic [RADDR_W-1:0]      mc_done_waddr_i,
  input  logic                    flush_i,
  output logic [NRD-1:0]          fwd_sel_o,
  output logic [NRD*XLEN-1:0]     fwd_data_o,
  output logic                    stall_o,
  output logic                    flush_o,
  output logic                    mc_busy_o,
  output logic                    mc_timeout_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]             perf_lu_stall_o,
  output logic [31:0]             perf_sb_stall_o,
  output logic [31:0]             perf_flush_o
`endif
);

  localparam int NREG  = 1 << RADDR_W;
  localparam int CNT_W = $clog2(MC_TIMEOUT) + 1;

  mc_state_e            state;
  logic [NREG-1:0]      pend;
  logic [NREG-1:0]      pend_eff;
  logic [CNT_W-1:0]     cnt;
  logic [NRD-1:0]       sel_raw;
  logic [NRD-1:0]       nvld;
  logic [NRD*XLEN-1:0]  data_raw;
  logic                 raw_haz;
  logic                 lu_haz;
  logic                 sb_haz;
  logic                 start_ok;

  for (genvar p = 0; p < NRD; p++) begin : g_port
    fwd_port_sel #(
      .XLEN    (XLEN),
      .RADDR_W (RADDR_W),
      .NFWD    (NFWD)
    ) u_sel (
      .re        (id_re_i[p]),
      .raddr     (id_raddr_i[p*RADDR_W +: RADDR_W]),
      .fwd_we    (fwd_we_i),
      .fwd_waddr (fwd_waddr_i),
      .fwd_data  (fwd_data_i),
      .fwd_dvld  (fwd_dvld_i),
      .sel       (sel_raw[p]),
      .data      (data_raw[p*XLEN +: XLEN]),
      .nvld      (nvld[p])
    );
  end

  // Scoreboard RAW check; a completing op releases its register in the same cycle it writes back.
  always_comb begin
    pend_eff = pend;
    if ((state == BUSY) && mc_done_i) pend_eff[mc_done_waddr_i] = 1'b0;
    raw_haz = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      if (id_re_i[p] && pend_eff[id_raddr_i[p*RADDR_W +: RADDR_W]]) raw_haz = 1'b1;
    end
  end

  assign lu_haz   = |nvld;
  assign sb_haz   = raw_haz || (id_we_i && pend_eff[id_waddr_i]) ||
                    (mc_start_i && (state == BUSY));
  assign stall_o  = !rst && id_valid_i && !flush_i && (lu_haz || sb_haz);
  assign flush_o  = !rst && flush_i;
  assign fwd_sel_o  = rst ? '0 : sel_raw;
  assign fwd_data_o = rst ? '0 : data_raw;
  assign mc_busy_o  = (state == BUSY);
  assign start_ok = mc_start_i && id_valid_i && !stall_o && !flush_i && (id_waddr_i != '0);

  // Multicycle op tracking: scoreboard bit, watchdog and completion / timeout handling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pend         <= '0;
      cnt          <= '0;
      mc_timeout_o <= 1'b0;
    end else begin
      mc_timeout_o <= 1'b0;
      if (state == IDLE) begin
        if (start_ok) begin
          state            <= BUSY;
          pend[id_waddr_i] <= 1'b1;
          cnt              <= '0;
        end
      end else begin
        if (mc_done_i) begin
          state                 <= IDLE;
          pend[mc_done_waddr_i] <= 1'b0;
        end else if (cnt == CNT_W'(MC_TIMEOUT - 1)) begin
          state        <= IDLE;
          pend         <= '0;
          mc_timeout_o <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating event counters; a stall with both causes bumps both.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lu_stall_o <= '0;
      perf_sb_stall_o <= '0;
      perf_flush_o    <= '0;
    end else begin
      if (stall_o && lu_haz && (perf_lu_stall_o != '1)) perf_lu_stall_o <= perf_lu_stall_o + 32'd1;
      if (stall_o && sb_haz && (perf_sb_stall_o != '1)) perf_sb_stall_o <= perf_sb_stall_o + 32'd1;
      if (flush_o && (perf_flush_o != '1))              perf_flush_o    <= perf_flush_o + 32'd1;
    end
  end
`endif

endmodule
